line_bank_ctrl: RTL and testbench

//  Ping-pong scheduler for a bank of single-port-per-side line RAMs between the camera

---
 rtl/line_buf_pkg.sv | 14 +
 rtl/line_bank_tracker.sv | 53 +++++
 rtl/line_bank_ctrl.sv | 112 +++++++++++
 tb/tb_line_bank_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared FSM state types and width helpers for the line bank scheduler.
package line_buf_pkg;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
    typedef enum logic {R_IDLE, R_READ} rstate_e;
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int bank_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/line_bank_tracker.sv
// line_bank_tracker: full mask, stored line lengths and FIFO write/read bank pointers.
module line_bank_tracker
    import line_buf_pkg::*;
#(
    parameter int BANKS = 2,
    parameter int BW    = 1,
    parameter int LW    = 11
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_commit,
    input  logic [LW-1:0] i_len,
    input  logic          i_release,
    output logic          o_can_write,
    output logic          o_line_rdy,
    output logic [BW-1:0] o_wr_ptr,
    output logic [BW-1:0] o_rd_ptr,
    output logic [LW-1:0] o_rd_len
);
    logic [BANKS-1:0] r_full;
    logic [LW-1:0]    r_len [BANKS];
    logic [BW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [BANKS-1:0] w_set, w_clr;
    logic [BW-1:0]    w_wr_next, w_rd_next;

    assign w_set     = i_commit  ? (BANKS'(1) << r_wr_ptr) : '0;
    assign w_clr     = i_release ? (BANKS'(1) << r_rd_ptr) : '0;
    assign w_wr_next = (r_wr_ptr == BW'(BANKS - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == BW'(BANKS - 1)) ? '0 : r_rd_ptr + 1'b1;

    // Commit and release always target different banks, so set and clear compose freely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int b = 0; b < BANKS; b++) r_len[b] <= '0;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
            if (i_commit) begin
                r_len[r_wr_ptr] <= i_len;
                r_wr_ptr        <= w_wr_next;
            end
            if (i_release) r_rd_ptr <= w_rd_next;
        end
    end

    assign o_can_write = ~r_full[r_wr_ptr];
    assign o_line_rdy  = |r_full;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_rd_len    = r_len[r_rd_ptr];
endmodule

// File: rtl/line_bank_ctrl.sv
// line_bank_ctrl: ping-pong line RAM scheduler between a pixel stream writer and a line reader.
module line_bank_ctrl
    import line_buf_pkg::*;
#(
    parameter int NUM   = 1280,
    parameter int BANKS = 2,
    localparam int AW   = addr_w(NUM),
    localparam int BW   = bank_w(BANKS),
    localparam int LW   = len_w(NUM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_in_de,
    output logic          o_wr_en,
    output logic [BW-1:0] o_wr_bank,
    output logic [AW-1:0] o_wr_addr,
    input  logic          i_rd_start,
    output logic          o_rd_en,
    output logic [BW-1:0] o_rd_bank,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_last,
    output logic          o_line_rdy,
    output logic          o_drop,
    output logic          o_trunc
);
    wstate_e       r_ws, w_ws_nx;
    rstate_e       r_rs, w_rs_nx;
    logic          r_de_d, r_ovf;
    logic [LW-1:0] r_wcnt;
    logic [AW-1:0] r_raddr;
    logic          w_rise, w_room, w_can_write, w_line_rdy, w_commit, w_rd_last;
    logic          w_wr_en, w_drop, w_trunc;
    logic [BW-1:0] w_wr_ptr, w_rd_ptr;
    logic [LW-1:0] w_rd_len;

    line_bank_tracker #(.BANKS(BANKS), .BW(BW), .LW(LW)) u_trk (
        .clk         (clk),
        .rstn        (rstn),
        .i_commit    (w_commit),
        .i_len       (r_wcnt),
        .i_release   (w_rd_last),
        .o_can_write (w_can_write),
        .o_line_rdy  (w_line_rdy),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_rd_len    (w_rd_len)
    );

    // The first pixel is written combinationally, so the edge detect is masked during reset.
    assign w_rise    = rstn & i_in_de & ~r_de_d;
    assign w_room    = r_wcnt < LW'(NUM);
    assign w_rd_last = (r_rs == R_READ) && (LW'(r_raddr) + LW'(1) == w_rd_len);

    always_comb begin
        w_ws_nx  = r_ws;
        w_rs_nx  = r_rs;
        w_wr_en  = 1'b0;
        w_drop   = 1'b0;
        w_trunc  = 1'b0;
        w_commit = 1'b0;
        case (r_ws)
            W_IDLE: if (w_rise) begin
                w_ws_nx = w_can_write ? W_FILL : W_DROP;
                w_wr_en = w_can_write;
                w_drop  = ~w_can_write;
            end
            W_FILL: if (!i_in_de) begin
                w_commit = 1'b1;
                w_ws_nx  = W_IDLE;
            end else begin
                w_wr_en = w_room;
                w_trunc = ~w_room & ~r_ovf;
            end
            W_DROP:  w_ws_nx = i_in_de ? W_DROP : W_IDLE;
            default: w_ws_nx = W_IDLE;
        endcase
        case (r_rs)
            R_IDLE:  w_rs_nx = (i_rd_start && w_line_rdy) ? R_READ : R_IDLE;
            R_READ:  w_rs_nx = w_rd_last ? R_IDLE : R_READ;
            default: w_rs_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ws    <= W_IDLE;
            r_rs    <= R_IDLE;
            r_de_d  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wcnt  <= '0;
            r_raddr <= '0;
        end else begin
            r_ws    <= w_ws_nx;
            r_rs    <= w_rs_nx;
            r_de_d  <= i_in_de;
            r_ovf   <= w_commit ? 1'b0 : (r_ovf | w_trunc);
            r_wcnt  <= w_commit ? '0 : (w_wr_en ? r_wcnt + 1'b1 : r_wcnt);
            r_raddr <= (r_rs == R_READ && !w_rd_last) ? r_raddr + 1'b1 : '0;
        end
    end

    assign o_wr_en    = w_wr_en;
    assign o_wr_bank  = w_wr_ptr;
    assign o_wr_addr  = w_wr_en ? r_wcnt[AW-1:0] : '0;
    assign o_rd_en    = (r_rs == R_READ);
    assign o_rd_bank  = w_rd_ptr;
    assign o_rd_addr  = r_raddr;
    assign o_rd_last  = w_rd_last;
    assign o_line_rdy = w_line_rdy;
    assign o_drop     = w_drop;
    assign o_trunc    = w_trunc;
endmodule

// File: tb/tb_line_bank_ctrl.sv
// tb_line_bank_ctrl: transaction table, corner sequences and random traffic against a queue-based model.
module tb_line_bank_ctrl;
    localparam int NUM   = 8;
    localparam int BANKS = 2;

    logic       clk = 1'b0, rstn = 1'b0, in_de = 1'b0, rd_start = 1'b0;
    logic       o_wr_en, o_rd_en, o_rd_last, o_line_rdy, o_drop, o_trunc;
    logic [0:0] o_wr_bank, o_rd_bank;
    logic [2:0] o_wr_addr, o_rd_addr;
    int         n_chk = 0, n_fail = 0;

    line_bank_ctrl #(.NUM(NUM), .BANKS(BANKS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_in_de    (in_de),
        .o_wr_en    (o_wr_en),
        .o_wr_bank  (o_wr_bank),
        .o_wr_addr  (o_wr_addr),
        .i_rd_start (rd_start),
        .o_rd_en    (o_rd_en),
        .o_rd_bank  (o_rd_bank),
        .o_rd_addr  (o_rd_addr),
        .o_rd_last  (o_rd_last),
        .o_line_rdy (o_line_rdy),
        .o_drop     (o_drop),
        .o_trunc    (o_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: full banks are a FIFO queue of (bank, length); a bank is writable
    // whenever fewer than BANKS lines are waiting, since banks are handed over in order.
    int mq_bank[$], mq_len[$];
    int m_wp, m_rp, m_wmode, m_wcnt, m_ridx;
    bit m_prev, m_rd;

    always @(negedge clk) begin : model
        bit         rise, free, wfill, wstart, last, commit, start;
        logic [13:0] e, a;
        a = {o_wr_en, o_wr_bank, o_wr_addr, o_rd_en, o_rd_bank, o_rd_addr,
             o_rd_last, o_line_rdy, o_drop, o_trunc};
        if (!rstn) begin
            mq_bank.delete();
            mq_len.delete();
            m_wp = 0; m_rp = 0; m_wmode = 0; m_wcnt = 0; m_ridx = 0;
            m_prev = 0; m_rd = 0;
            e = '0;
        end else begin
            rise   = in_de && !m_prev;
            free   = mq_bank.size() < BANKS;
            wfill  = m_wmode == 1 && in_de && m_wcnt < NUM;
            wstart = m_wmode == 0 && rise && free;
            last   = m_rd && (m_ridx == mq_len[0] - 1);
            e = {wfill || wstart, 1'(m_wp), wfill ? 3'(m_wcnt) : 3'd0,
                 m_rd, 1'(m_rp), m_rd ? 3'(m_ridx) : 3'd0, last,
                 mq_bank.size() > 0, m_wmode == 0 && rise && !free,
                 m_wmode == 1 && in_de && m_wcnt == NUM};
            commit = m_wmode == 1 && !in_de;
            start  = !m_rd && rd_start && mq_bank.size() > 0;
            if (m_wmode == 0) begin
                if (rise) begin
                    m_wmode = free ? 1 : 2;
                    m_wcnt  = free ? 1 : 0;
                end
            end else if (m_wmode == 1) begin
                if (in_de) m_wcnt++;
                else if (commit) begin
                    mq_bank.push_back(m_wp);
                    mq_len.push_back(m_wcnt < NUM ? m_wcnt : NUM);
                    m_wp = (m_wp + 1) % BANKS;
                    m_wmode = 0;
                    m_wcnt = 0;
                end
            end else if (!in_de) m_wmode = 0;
            if (m_rd) begin
                if (last) begin
                    void'(mq_bank.pop_front());
                    void'(mq_len.pop_front());
                    m_rp = (m_rp + 1) % BANKS;
                    m_rd = 0;
                end else m_ridx++;
            end else if (start) begin
                m_rd = 1;
                m_ridx = 0;
            end
            m_prev = in_de;
        end
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_model @%0t: got %h, expected %h", $time, a, e);
        end
    end

    task automatic write_line(input int len, output int nw, output int wb, output int nd,
                              output int ntr, output int tp, output bit aok);
        nw = 0; wb = -1; nd = 0; ntr = 0; tp = 0; aok = 1;
        for (int i = 0; i < len + 2; i++) begin
            in_de = (i < len);
            @(negedge clk);
            if (o_wr_en) begin
                if (int'(o_wr_addr) != nw) aok = 0;
                wb = int'(o_wr_bank);
                nw++;
            end
            if (o_drop) nd++;
            if (o_trunc) begin
                ntr++;
                tp = i + 1;
            end
            step();
        end
    endtask

    task automatic read_line(output int n, output int rb, output bit done, output bit aok);
        n = 0; rb = -1; done = 0; aok = 1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int c = 0; c < NUM + 4 && !done; c++) begin
            @(negedge clk);
            if (o_rd_en) begin
                if (int'(o_rd_addr) != n) aok = 0;
                rb = int'(o_rd_bank);
                n++;
                done = o_rd_last;
            end else if (o_rd_last) aok = 0;
            step();
        end
        step();
    endtask

    typedef struct {
        int len; bit rd;
        int ewb; int enw; int edrop; int etr; int etp;
        int erb; int ern;
    } vec_t;

    vec_t tbl[10];
    int   nw, wb, nd, ntr, tp, n, rb, cnt, hi, lo;
    bit   aok, done;

    initial begin
        tbl[0] = '{8,  1,  0, 8, 0, 0, 0,  0, 8};
        tbl[1] = '{5,  1,  1, 5, 0, 0, 0,  1, 5};
        tbl[2] = '{12, 1,  0, 8, 0, 1, 9,  0, 8};
        tbl[3] = '{3,  0,  1, 3, 0, 0, 0, -1, 0};
        tbl[4] = '{6,  0,  0, 6, 0, 0, 0, -1, 0};
        tbl[5] = '{4,  1, -1, 0, 1, 0, 0,  1, 3};
        tbl[6] = '{2,  1,  1, 2, 0, 0, 0,  0, 6};
        tbl[7] = '{1,  1,  0, 1, 0, 0, 0,  1, 2};
        tbl[8] = '{0,  1, -1, 0, 0, 0, 0,  0, 1};
        tbl[9] = '{0,  1, -1, 0, 0, 0, 0, -1, 0};

        for (int i = 0; i < 6; i++) begin
            in_de = (i % 2 == 1);
            @(negedge clk);
            chk("rst_wr_en", o_wr_en, 0);
            chk("rst_line_rdy", o_line_rdy, 0);
            step();
        end
        in_de = 1'b0;
        rstn  = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            write_line(tbl[i].len, nw, wb, nd, ntr, tp, aok);
            chk($sformatf("v%0d_nwr", i), nw, tbl[i].enw);
            chk($sformatf("v%0d_wbank", i), wb, tbl[i].ewb);
            chk($sformatf("v%0d_drop", i), nd, tbl[i].edrop);
            chk($sformatf("v%0d_trunc", i), ntr, tbl[i].etr);
            chk($sformatf("v%0d_trunc_pix", i), tp, tbl[i].etp);
            chk($sformatf("v%0d_waddr", i), int'(aok), 1);
            if (tbl[i].rd) begin
                read_line(n, rb, done, aok);
                chk($sformatf("v%0d_nrd", i), n, tbl[i].ern);
                chk($sformatf("v%0d_rbank", i), rb, tbl[i].erb);
                chk($sformatf("v%0d_rlast", i), int'(done), int'(tbl[i].ern > 0));
                chk($sformatf("v%0d_raddr", i), int'(aok), 1);
            end
        end

        // reset in the middle of a write
        in_de = 1'b1;
        repeat (3) step();
        rstn = 1'b0;
        @(negedge clk);
        chk("rstw_wr_en", o_wr_en, 0);
        chk("rstw_line_rdy", o_line_rdy, 0);
        in_de = 1'b0;
        step();
        rstn = 1'b1;
        step();

        // reset in the middle of a read
        write_line(8, nw, wb, nd, ntr, tp, aok);
        chk("rstr_pre_wbank", wb, 0);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        repeat (3) step();
        rstn = 1'b0;
        @(negedge clk);
        chk("rstr_rd_en", o_rd_en, 0);
        chk("rstr_line_rdy", o_line_rdy, 0);
        step();
        rstn = 1'b1;
        step();
        write_line(8, nw, wb, nd, ntr, tp, aok);
        chk("rstr_post_wbank", wb, 0);
        chk("rstr_post_nwr", nw, 8);
        chk("rstr_post_drop", nd, 0);
        chk("rstr_post_waddr", int'(aok), 1);
        read_line(n, rb, done, aok);
        chk("rstr_post_rbank", rb, 0);
        chk("rstr_post_nrd", n, 8);

        // bank1 commit coincides with bank0 rd_last; mid-read rd_start ignored
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        write_line(8, nw, wb, nd, ntr, tp, aok);
        chk("cc_pre_wbank", wb, 0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            rd_start = (k == 0 || k == 3);
            in_de    = (k >= 4 && k <= 7);
            @(negedge clk);
            if (o_rd_en) cnt++;
            if (k == 4) chk("cc_wr_bank1", int'(o_wr_en && o_wr_bank == 1'b1), 1);
            if (k == 8) chk("cc_rd_last", int'(o_rd_last && o_rd_bank == 1'b0), 1);
            if (k == 9) chk("cc_line_rdy", o_line_rdy, 1);
            step();
        end
        rd_start = 1'b0;
        chk("cc_rd_count", cnt, 8);
        read_line(n, rb, done, aok);
        chk("cc_next_rbank", rb, 1);
        chk("cc_next_nrd", n, 4);
        write_line(2, nw, wb, nd, ntr, tp, aok);
        chk("cc_free_wbank", wb, 0);
        chk("cc_free_drop", nd, 0);
        read_line(n, rb, done, aok);
        chk("cc_last_rbank", rb, 0);
        chk("cc_last_nrd", n, 2);
        read_line(n, rb, done, aok);
        chk("cc_empty_nrd", n, 0);

        for (int s = 0; s < 60; s++) begin
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi + lo; c++) begin
                in_de    = (c < hi);
                rd_start = ($urandom_range(0, 4) == 0);
                step();
            end
            if (s == 30) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end
        end
        in_de    = 1'b0;
        rd_start = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
